// File: rtl/alarm_pkg.sv
// Shared definitions for the 3-line buzzer alarm interface (encoder and decoder sides):
// zone encoding, nominal pulse length, decoder FSM states and one-hot helpers.
package alarm_pkg;

    typedef enum logic [1:0] {
        ZONE_NONE = 2'd0,
        ZONE1     = 2'd1,
        ZONE2     = 2'd2,
        ZONE3     = 2'd3
    } zone_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEASURE  = 2'd1,
        WAIT_LOW = 2'd2
    } state_e;

    localparam int PULSE_LEN_DEF = 31;

    // Buzzer line pattern that belongs to a zone; ZONE_NONE maps to all-low.
    function automatic logic [2:0] zone_mask(input zone_e z);
        logic [2:0] m;
        case (z)
            ZONE1:   m = 3'b001;
            ZONE2:   m = 3'b010;
            ZONE3:   m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    // Zone of a one-hot line pattern; anything not one-hot yields ZONE_NONE.
    function automatic zone_e onehot_zone(input logic [2:0] b);
        zone_e z;
        case (b)
            3'b001:  z = ZONE1;
            3'b010:  z = ZONE2;
            3'b100:  z = ZONE3;
            default: z = ZONE_NONE;
        endcase
        return z;
    endfunction

endpackage

// File: rtl/alarm_evt_slot.sv
// One-entry valid/ready holding register for decoded alarm events, with a sticky
// overflow flag raised when a push arrives while the slot is full and not draining.
module alarm_evt_slot
    import alarm_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             push,
    input  logic [1:0]       push_zone,
    input  logic [CNT_W-1:0] push_width,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [1:0]       evt_zone,
    output logic [CNT_W-1:0] evt_width,
    output logic             ovf
);

    logic             valid_q, valid_d;
    logic [1:0]       zone_q, zone_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             ovf_q, ovf_d;
    logic             pop_s;
    logic             accept_s;

    // Load on push when empty or draining this edge; otherwise drop and flag overflow.
    always_comb begin
        valid_d  = valid_q;
        zone_d   = zone_q;
        width_d  = width_q;
        ovf_d    = ovf_q;
        pop_s    = valid_q & evt_ready;
        accept_s = push & (~valid_q | pop_s);
        if (accept_s) begin
            valid_d = 1'b1;
            zone_d  = push_zone;
            width_d = push_width;
        end else if (pop_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (push && !accept_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Slot registers; frozen while the block is disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            zone_q  <= 2'd0;
            width_q <= '0;
            ovf_q   <= 1'b0;
        end else if (ena) begin
            valid_q <= valid_d;
            zone_q  <= zone_d;
            width_q <= width_d;
            ovf_q   <= ovf_d;
        end
    end

    assign evt_valid = valid_q;
    assign evt_zone  = zone_q;
    assign evt_width = width_q;
    assign ovf       = ovf_q;

endmodule

// File: rtl/alarm_pulse_decoder.sv
// Receive-side decoder for the 3-line buzzer alarm interface: validates each one-hot pulse
// length and emits one zone event per good pulse. ALARM_ZONE_COUNT_EN adds per-zone counters.
module alarm_pulse_decoder
    import alarm_pkg::*;
#(
    parameter int PULSE_LEN = PULSE_LEN_DEF,
    parameter int TOL       = 2,
    parameter int CNT_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [2:0]       buzz,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_zone,
    output logic [CNT_W-1:0] evt_width,
    output logic             err,
    output logic             ovf
`ifdef ALARM_ZONE_COUNT_EN
    ,
    output logic [7:0]       zone_cnt1,
    output logic [7:0]       zone_cnt2,
    output logic [7:0]       zone_cnt3
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PULSE_LEN + TOL + 1);
    localparam logic [CNT_W-1:0] LEN_MIN = CNT_W'(PULSE_LEN - TOL);
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(PULSE_LEN + TOL);

    logic [2:0]       buzz_q, buzz_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    zone_e            zone_q, zone_d;
    logic             err_q, err_d;
    logic             emit_s;

    // Pulse FSM: measure one-hot high time, reject multi-hot, zone changes and bad lengths.
    always_comb begin
        buzz_d  = buzz;
        state_d = state_q;
        cnt_d   = cnt_q;
        zone_d  = zone_q;
        err_d   = err_q;
        emit_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (buzz_q == 3'b000) begin
                    state_d = IDLE;
                end else if (onehot_zone(buzz_q) != ZONE_NONE) begin
                    state_d = MEASURE;
                    zone_d  = onehot_zone(buzz_q);
                    cnt_d   = CNT_W'(1);
                end else begin
                    err_d   = 1'b1;
                    state_d = WAIT_LOW;
                end
            end
            MEASURE: begin
                if (buzz_q == zone_mask(zone_q)) begin
                    // Saturate at CNT_MAX: reaching it is already a too-long pulse.
                    if (cnt_q >= CNT_MAX - CNT_W'(1)) begin
                        cnt_d   = CNT_MAX;
                        err_d   = 1'b1;
                        state_d = WAIT_LOW;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (buzz_q == 3'b000) begin
                    if ((cnt_q >= LEN_MIN) && (cnt_q <= LEN_MAX)) begin
                        emit_s = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    err_d   = 1'b1;
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (buzz_q == 3'b000) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_LOW;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Input sample, FSM state, width counter, latched zone and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            buzz_q  <= 3'b000;
            state_q <= IDLE;
            cnt_q   <= '0;
            zone_q  <= ZONE_NONE;
            err_q   <= 1'b0;
        end else if (ena) begin
            buzz_q  <= buzz_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zone_q  <= zone_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;

    alarm_evt_slot #(
        .CNT_W (CNT_W)
    ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .push       (emit_s),
        .push_zone  (zone_q),
        .push_width (cnt_q),
        .evt_ready  (evt_ready),
        .evt_valid  (evt_valid),
        .evt_zone   (evt_zone),
        .evt_width  (evt_width),
        .ovf        (ovf)
    );

`ifdef ALARM_ZONE_COUNT_EN
    logic [7:0] zcnt_q [3];
    logic [7:0] zcnt_d [3];
    logic       zinc_s;

    // Count only events the slot actually accepts; dropped events leave counters untouched.
    always_comb begin
        zinc_s = emit_s & (~evt_valid | evt_ready);
        for (int i = 0; i < 3; i++) begin
            if (zinc_s && (zone_q == zone_e'(2'(i + 1))) && (zcnt_q[i] != 8'hFF)) begin
                zcnt_d[i] = zcnt_q[i] + 8'd1;
            end else begin
                zcnt_d[i] = zcnt_q[i];
            end
        end
    end

    // Per-zone event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                zcnt_q[i] <= 8'd0;
            end
        end else if (ena) begin
            for (int i = 0; i < 3; i++) begin
                zcnt_q[i] <= zcnt_d[i];
            end
        end
    end

    assign zone_cnt1 = zcnt_q[0];
    assign zone_cnt2 = zcnt_q[1];
    assign zone_cnt3 = zcnt_q[2];
`endif

endmodule

// File: tb/tb_alarm_pulse_decoder.sv
// Self-checking bench for alarm_pulse_decoder: directed scenarios plus randomized pulse trains
// judged by a run-length reference model (a pulse is a maximal run of nonzero line samples).
module tb_alarm_pulse_decoder;

    localparam int CNT_W     = 6;
    localparam int PULSE_LEN = 31;
    localparam int TOL       = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic [2:0]       buzz;
    logic             evt_valid;
    logic             evt_ready;
    logic [1:0]       evt_zone;
    logic [CNT_W-1:0] evt_width;
    logic             err;
    logic             ovf;
`ifdef ALARM_ZONE_COUNT_EN
    logic [7:0]       zone_cnt1, zone_cnt2, zone_cnt3;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic       exp_err;
    logic       exp_ovf;
    bit         rnd_ready = 1'b0;

    always #5 clk = ~clk;

    alarm_pulse_decoder #(
        .PULSE_LEN (PULSE_LEN),
        .TOL       (TOL),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .buzz      (buzz),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_zone  (evt_zone),
        .evt_width (evt_width),
        .err       (err),
        .ovf       (ovf)
`ifdef ALARM_ZONE_COUNT_EN
        ,
        .zone_cnt1 (zone_cnt1),
        .zone_cnt2 (zone_cnt2),
        .zone_cnt3 (zone_cnt3)
`endif
    );

    // Record each handshake that completes on the coming rising edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && ena === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1)
            got_q.push_back({evt_zone, evt_width});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [2:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            buzz = v;
            if (rnd_ready) evt_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one nonzero run (optionally two segments) and predict its outcome from the rules.
    task automatic run(input logic [2:0] v1, input int l1, input logic [2:0] v2, input int l2,
                       input int gap);
        logic [1:0] z;
        int         len;
        hold(v1, l1);
        if (l2 > 0) hold(v2, l2);
        hold(3'b000, gap);
        len = l1 + l2;
        z   = v1[0] ? 2'd1 : (v1[1] ? 2'd2 : 2'd3);
        if ((l2 == 0 || v2 == v1) && $countones(v1) == 1 &&
            len >= PULSE_LEN - TOL && len <= PULSE_LEN + TOL)
            exp_q.push_back({z, 6'(len)});
        else
            exp_err = 1'b1;
    endtask

    task automatic compare_events(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_event"}, got_q[i], exp_q[i]);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_ovf"}, ovf, exp_ovf);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, evt_valid, 1'b0);
        check({tag, "_zone"}, evt_zone, 2'd0);
        check({tag, "_width"}, evt_width, 6'd0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_ovf"}, ovf, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        buzz = 3'b000;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        exp_err = 1'b0;
        exp_ovf = 1'b0;
        check_zero(tag);
    endtask

    initial begin
        rst       = 1'b1;
        ena       = 1'b1;
        buzz      = 3'b000;
        evt_ready = 1'b1;
        exp_err   = 1'b0;
        exp_ovf   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Nominal pulse with latency check: valid rises on the second edge after the pin falls.
        do_reset("rst1");
        hold(3'b001, 31);
        buzz = 3'b000;
        @(posedge clk);
        #1;
        check("lat_early", evt_valid, 1'b0);
        @(posedge clk);
        #1;
        check("lat_valid", evt_valid, 1'b1);
        check("lat_zone", evt_zone, 2'd1);
        check("lat_width", evt_width, 6'd31);
        exp_q.push_back({2'd1, 6'd31});
        hold(3'b000, 3);
        compare_events("t1");

        // Length boundaries: 29 and 33 accepted, 28, 34 and 10 rejected.
        do_reset("rst2");
        run(3'b010, 29, 3'b000, 0, 3);
        run(3'b100, 33, 3'b000, 0, 4);
        compare_events("t2_ok");
        run(3'b010, 28, 3'b000, 0, 4);
        compare_events("t2_short");
        do_reset("rst2b");
        run(3'b100, 34, 3'b000, 0, 4);
        compare_events("t2_long");
        do_reset("rst2c");
        run(3'b001, 10, 3'b000, 0, 4);
        compare_events("t2_10");

        // Stuck line: error at the 34th counted high cycle, then recovery.
        do_reset("rst3");
        hold(3'b001, 34);
        check("t3_err_before", err, 1'b0);
        hold(3'b001, 1);
        check("t3_err_at", err, 1'b1);
        hold(3'b001, 5);
        hold(3'b000, 3);
        exp_err = 1'b1;
        run(3'b001, 31, 3'b000, 0, 4);
        compare_events("t3");

        // Multi-hot and zone change mid-pulse.
        do_reset("rst4");
        run(3'b011, 31, 3'b000, 0, 4);
        compare_events("t4_multi");
        do_reset("rst4b");
        run(3'b001, 10, 3'b010, 20, 4);
        compare_events("t4_change");

        // Back-to-back pulses separated by a single low cycle.
        do_reset("rst4c");
        run(3'b001, 31, 3'b000, 0, 1);
        run(3'b100, 30, 3'b000, 0, 4);
        compare_events("t4_b2b");

        // Consumer stalled: first event held, later ones dropped with overflow.
        do_reset("rst5");
        evt_ready = 1'b0;
        hold(3'b001, 31);
        hold(3'b000, 3);
        hold(3'b010, 31);
        hold(3'b000, 3);
        hold(3'b100, 31);
        hold(3'b000, 3);
        check("t5_valid", evt_valid, 1'b1);
        check("t5_zone", evt_zone, 2'd1);
        check("t5_width", evt_width, 6'd31);
        check("t5_ovf", ovf, 1'b1);
        evt_ready = 1'b1;
        hold(3'b000, 1);
        evt_ready = 1'b0;
        hold(3'b000, 3);
        check("t5_drained", evt_valid, 1'b0);
        exp_q.push_back({2'd1, 6'd31});
        exp_ovf = 1'b1;
        compare_events("t5");
        evt_ready = 1'b1;

        // Reset in the middle of a pulse; the remainder is a short pulse.
        do_reset("rst6");
        hold(3'b001, 15);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("t6_midrst");
        hold(3'b001, 16);
        hold(3'b000, 4);
        exp_err = 1'b1;
        compare_events("t6_rst");

        // Enable low mid-pulse freezes measurement: 10 + 21 enabled high cycles = 31.
        do_reset("rst6b");
        hold(3'b001, 10);
        ena = 1'b0;
        hold(3'b001, 20);
        check("t6_frozen_err", err, 1'b0);
        ena = 1'b1;
        hold(3'b001, 21);
        hold(3'b000, 4);
        exp_q.push_back({2'd1, 6'd31});
        compare_events("t6_ena");

        // Randomized pulse trains with a randomly stalling consumer.
        do_reset("rst7");
        rnd_ready = 1'b1;
        for (int r = 0; r < 30; r++) begin
            int          kind;
            logic [2:0]  oh;
            logic [2:0]  oh2;
            logic [2:0]  multi;
            logic [2:0]  ohs [3];
            logic [2:0]  mhs [4];
            ohs   = '{3'b001, 3'b010, 3'b100};
            mhs   = '{3'b011, 3'b101, 3'b110, 3'b111};
            kind  = $urandom_range(0, 7);
            oh    = ohs[$urandom_range(0, 2)];
            oh2   = ohs[$urandom_range(0, 2)];
            multi = mhs[$urandom_range(0, 3)];
            if (kind == 0)
                run(multi, $urandom_range(5, 35), 3'b000, 0, $urandom_range(1, 4));
            else if (kind == 1)
                run(oh, $urandom_range(5, 20), oh2, $urandom_range(5, 20), $urandom_range(1, 4));
            else
                run(oh, $urandom_range(26, 36), 3'b000, 0, $urandom_range(1, 4));
        end
        rnd_ready = 1'b0;
        evt_ready = 1'b1;
        hold(3'b000, 6);
        compare_events("t7_rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
